// File: rtl/digit_entry_n_pkg.sv
// Game-state encodings shared between the top-level game FSM and the entry block.
package game_state_pkg;

    typedef enum logic [3:0] {
        ST_READY    = 4'b0010,
        ST_QUESTION = 4'b0011,
        ST_INPUT    = 4'b0100,
        ST_DRAW     = 4'b0110,
        ST_WRONG    = 4'b0111,
        ST_OUCH     = 4'b1000,
        ST_GOOD     = 4'b1001,
        ST_WIN      = 4'b1010,
        ST_LOSE     = 4'b1011
    } game_state_e;

    // States in which the answer counters are wiped for the next round
    function automatic logic zeroes_counters(logic [3:0] s);
        return (s == ST_DRAW) || (s == ST_OUCH) || (s == ST_GOOD) ||
               (s == ST_WIN)  || (s == ST_LOSE);
    endfunction

endpackage

// File: rtl/digit_entry_n_if.sv
// Player-entry bus: game state, question word and buttons in; display and answer out.
interface digit_entry_n_if #(
    parameter int NDIG    = 3,
    parameter int STATE_W = 4
);
    logic [STATE_W-1:0]       STATE;
    logic [8*NDIG-1:0]        QUESTION;
    logic [NDIG-1:0]          SEL;
    logic                     DOWN;
    logic                     CLR;
    logic                     DEC;
    logic [NDIG-1:0][3:0]     DIG;
    logic [NDIG-1:0][3:0]     QDIG;
    logic [NDIG-1:0][3:0]     ANS;
    logic                     ANS_VALID;
    logic                     ANS_ERR;
    logic                     QUE_OK;
    logic                     LED;

    modport master (
        output STATE, QUESTION, SEL, DOWN, CLR, DEC,
        input  DIG, QDIG, ANS, ANS_VALID, ANS_ERR, QUE_OK, LED
    );

    modport slave (
        input  STATE, QUESTION, SEL, DOWN, CLR, DEC,
        output DIG, QDIG, ANS, ANS_VALID, ANS_ERR, QUE_OK, LED
    );
endinterface

// File: rtl/digit_entry_n_counter.sv
// One BCD answer digit: wraps between DIG_MIN and DIG_MAX when stepped up or down.
module digit_counter #(
    parameter int DIG_MIN = 1,
    parameter int DIG_MAX = 9
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       step,
    input  logic       down,
    input  logic       clr,
    output logic [3:0] cnt
);
    localparam logic [3:0] LO = 4'(DIG_MIN);
    localparam logic [3:0] HI = 4'(DIG_MAX);

    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt <= 4'd0;
        end else if (clr) begin
            cnt <= 4'd0;
        end else if (step) begin
            // Stepping down from 0 (cleared) lands on the top value
            if (down) cnt <= (cnt <= LO) ? HI : cnt - 4'd1;
            else      cnt <= (cnt == HI) ? LO : cnt + 4'd1;
        end
    end
endmodule

// File: rtl/digit_entry_n.sv
// Answer-entry block: button edges step NDIG digit counters, commits latch the answer,
// and the question word is captured and forwarded to the 7-segment path.
module digit_entry_n
    import game_state_pkg::*;
#(
    parameter int NDIG    = 3,
    parameter int DIG_MIN = 1,
    parameter int DIG_MAX = 9,
    parameter int STATE_W = 4
) (
    input logic            CLK,
    input logic            RST,
    digit_entry_n_if.slave bus
);
    logic                 in_ready, in_question, in_input, in_wrong, force_zero;
    logic [NDIG-1:0]      sel_q, sel_rise, sel_pick, step_en;
    logic                 clr_q, dec_q, clr_rise, dec_rise, commit;
    logic                 cnt_clr, all_nz, q_load;
    logic [NDIG-1:0][3:0] cnt, q_r, dig_r, qdig_r, ans_r;
    logic                 valid_r, err_r;
    logic [1:0]           ok_pipe;

    assign in_ready    = bus.STATE == STATE_W'(ST_READY);
    assign in_question = bus.STATE == STATE_W'(ST_QUESTION);
    assign in_input    = bus.STATE == STATE_W'(ST_INPUT);
    assign in_wrong    = bus.STATE == STATE_W'(ST_WRONG);
    assign force_zero  = zeroes_counters(bus.STATE[3:0]) && (bus.STATE >> 4) == '0;

    // Edge registers follow the level even during reset, so a button held
    // through reset release is not seen as a fresh press.
    always_ff @(posedge CLK) begin
        sel_q <= bus.SEL;
        clr_q <= bus.CLR;
        dec_q <= bus.DEC;
    end

    assign sel_rise = bus.SEL & ~sel_q;
    assign clr_rise = bus.CLR & ~clr_q;
    assign dec_rise = bus.DEC & ~dec_q;
    assign sel_pick = sel_rise & (-sel_rise);
    assign step_en  = in_input ? sel_pick : '0;
    assign cnt_clr  = force_zero | (in_input & clr_rise & ~(|sel_rise));
    assign commit   = in_input & dec_rise;

    for (genvar i = 0; i < NDIG; i++) begin : g_dig
        digit_counter #(
            .DIG_MIN (DIG_MIN),
            .DIG_MAX (DIG_MAX)
        ) u_dig (
            .CLK  (CLK),
            .RST  (RST),
            .step (step_en[i]),
            .down (bus.DOWN),
            .clr  (cnt_clr),
            .cnt  (cnt[i])
        );
    end

    always_comb begin
        all_nz = 1'b1;
        for (int i = 0; i < NDIG; i++)
            if (cnt[i] == 4'd0) all_nz = 1'b0;
    end

    assign q_load = (in_ready & (|bus.QUESTION)) | in_question | in_input | in_wrong;

    always_ff @(posedge CLK) begin
        if (RST) begin
            q_r     <= '0;
            ok_pipe <= '0;
            dig_r   <= '0;
            qdig_r  <= '0;
            ans_r   <= '0;
            valid_r <= 1'b0;
            err_r   <= 1'b0;
        end else begin
            q_r     <= q_load ? bus.QUESTION[8*NDIG-1:4*NDIG] : '0;
            ok_pipe <= {ok_pipe[0], |q_r};
            dig_r   <= in_input ? cnt : '0;
            qdig_r  <= in_question ? q_r : '0;
            // Commit samples counters before this cycle's step lands
            if (commit) ans_r <= cnt;
            valid_r <= commit & all_nz;
            err_r   <= commit & ~all_nz;
        end
    end

    assign bus.DIG       = dig_r;
    assign bus.QDIG      = qdig_r;
    assign bus.ANS       = ans_r;
    assign bus.ANS_VALID = valid_r;
    assign bus.ANS_ERR   = err_r;
    assign bus.QUE_OK    = ok_pipe[0];
    assign bus.LED       = ok_pipe[1];
endmodule

// File: tb/tb_digit_entry_n.sv
// Directed bench for digit_entry_n: a per-cycle reference model plus literal spot checks.
module tb_digit_entry_n;
    logic CLK = 1'b0;
    logic RST;

    digit_entry_n_if #(.NDIG(3), .STATE_W(4)) bus ();

    digit_entry_n #(
        .NDIG    (3),
        .DIG_MIN (1),
        .DIG_MAX (9),
        .STATE_W (4)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    int n_chk = 0;
    int n_err = 0;

    // Reference model state (digit values as plain integers)
    int md[3];
    int m_ans, m_dig, m_qdig, mq;
    bit m_valid, m_err, m_ok, m_led;
    int p_sel;
    bit p_clr, p_dec;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int digits_val();
        return md[0] + 16 * md[1] + 256 * md[2];
    endfunction

    // One clock: update the model from the inputs seen at the edge, then compare at negedge.
    task automatic tick();
        int st, sel, rise, q, cur;
        bit done;
        @(posedge CLK);
        st  = int'(bus.STATE);
        sel = int'(bus.SEL);
        q   = int'(bus.QUESTION);
        if (RST) begin
            md = '{0, 0, 0};
            m_ans = 0; m_dig = 0; m_qdig = 0; mq = 0;
            m_valid = 0; m_err = 0; m_ok = 0; m_led = 0;
        end else begin
            rise = sel & ~p_sel & 7;
            cur  = digits_val();
            if (st == 4 && bus.DEC && !p_dec) begin
                m_ans   = cur;
                m_valid = (md[0] != 0) && (md[1] != 0) && (md[2] != 0);
                m_err   = !m_valid;
            end else begin
                m_valid = 0;
                m_err   = 0;
            end
            m_dig  = (st == 4) ? cur : 0;
            m_qdig = (st == 3) ? mq : 0;
            m_led  = m_ok;
            m_ok   = (mq != 0);
            mq     = ((st == 2 && q != 0) || st == 3 || st == 4 || st == 7) ? (q >> 12) : 0;
            if (st == 4) begin
                if (rise != 0) begin
                    done = 0;
                    for (int i = 0; i < 3; i++) begin
                        if (!done && rise[i]) begin
                            done = 1;
                            if (bus.DOWN) md[i] = (md[i] <= 1) ? 9 : md[i] - 1;
                            else          md[i] = md[i] % 9 + 1;
                        end
                    end
                end else if (bus.CLR && !p_clr) begin
                    md = '{0, 0, 0};
                end
            end else if (st == 6 || (st >= 8 && st <= 11)) begin
                md = '{0, 0, 0};
            end
        end
        p_sel = sel;
        p_clr = bus.CLR;
        p_dec = bus.DEC;
        @(negedge CLK);
        chk("DIG",       32'(bus.DIG),  32'(m_dig));
        chk("QDIG",      32'(bus.QDIG), 32'(m_qdig));
        chk("ANS",       32'(bus.ANS),  32'(m_ans));
        chk("ANS_VALID", 32'(bus.ANS_VALID), 32'(m_valid));
        chk("ANS_ERR",   32'(bus.ANS_ERR),   32'(m_err));
        chk("QUE_OK",    32'(bus.QUE_OK),    32'(m_ok));
        chk("LED",       32'(bus.LED),       32'(m_led));
    endtask

    task automatic press(input logic [2:0] mask, input int n);
        for (int i = 0; i < n; i++) begin
            bus.SEL = mask; tick();
            bus.SEL = 3'b000; tick();
        end
    endtask

    task automatic press_clr();
        bus.CLR = 1'b1; tick();
        bus.CLR = 1'b0; tick();
    endtask

    int seq[10] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 1};

    initial begin
        RST = 1'b1;
        bus.STATE = 4'b0100; bus.QUESTION = '0;
        bus.SEL = '0; bus.DOWN = 1'b0; bus.CLR = 1'b0; bus.DEC = 1'b0;
        tick(); tick();
        chk("rst_DIG",   32'(bus.DIG), 32'h0);
        chk("rst_ANS",   32'(bus.ANS), 32'h0);
        chk("rst_QUEOK", 32'(bus.QUE_OK), 32'h0);
        RST = 1'b0;
        tick();

        // Ten separate presses of digit 0: 1..9 then wrap to 1
        for (int k = 0; k < 10; k++) begin
            press(3'b001, 1);
            chk("step_up_seq", 32'(bus.DIG[0]), 32'(seq[k]));
        end
        // Held button steps once
        bus.SEL = 3'b001;
        for (int k = 0; k < 20; k++) tick();
        bus.SEL = 3'b000; tick();
        chk("held_once", 32'(bus.DIG[0]), 32'h2);

        press_clr();
        chk("clear", 32'(bus.DIG), 32'h000);

        bus.DOWN = 1'b1;
        press(3'b010, 1);
        chk("down_from_0", 32'(bus.DIG[1]), 32'h9);
        press(3'b010, 1);
        chk("down_9_to_8", 32'(bus.DIG[1]), 32'h8);
        bus.DOWN = 1'b0;

        // Two SEL edges plus CLR: only digit 0 steps
        bus.SEL = 3'b011; bus.CLR = 1'b1; tick();
        bus.SEL = 3'b000; bus.CLR = 1'b0; tick();
        chk("sel_beats_clr", 32'(bus.DIG), 32'h081);

        press_clr();
        press(3'b001, 3); press(3'b010, 5); press(3'b100, 7);
        chk("digits_357", 32'(bus.DIG), 32'h753);
        bus.DEC = 1'b1; tick();
        chk("commit_ans",   32'(bus.ANS), 32'h753);
        chk("commit_valid", 32'(bus.ANS_VALID), 32'h1);
        bus.DEC = 1'b0; tick();
        chk("valid_1cycle", 32'(bus.ANS_VALID), 32'h0);

        press_clr();
        press(3'b001, 3); press(3'b100, 7);
        bus.DEC = 1'b1; tick();
        chk("err_ans",   32'(bus.ANS), 32'h703);
        chk("err_pulse", 32'(bus.ANS_ERR), 32'h1);
        bus.DEC = 1'b0; tick();

        // Commit concurrent with a step captures the old value
        bus.DEC = 1'b1; bus.SEL = 3'b001; tick();
        bus.DEC = 1'b0; bus.SEL = 3'b000; tick();
        chk("commit_old_ans", 32'(bus.ANS), 32'h703);
        chk("commit_step",    32'(bus.DIG), 32'h704);

        // Question path
        bus.QUESTION = 24'h123000; bus.STATE = 4'b0010; tick();
        bus.STATE = 4'b0011; tick();
        chk("que_ok_2", 32'(bus.QUE_OK), 32'h1);
        chk("led_not_yet", 32'(bus.LED), 32'h0);
        chk("qdig", 32'(bus.QDIG), 32'h123);
        tick();
        chk("led_3", 32'(bus.LED), 32'h1);

        bus.STATE = 4'b1010; tick(); tick();
        chk("win_queok_drop", 32'(bus.QUE_OK), 32'h0);
        chk("win_dig", 32'(bus.DIG), 32'h0);
        bus.STATE = 4'b0100; tick(); tick();
        chk("win_counters_0", 32'(bus.DIG), 32'h000);

        // Reset mid-entry with SEL[2] held
        press(3'b001, 2);
        bus.SEL = 3'b100; RST = 1'b1; tick();
        chk("rst_mid_DIG", 32'(bus.DIG), 32'h0);
        chk("rst_mid_ANS", 32'(bus.ANS), 32'h0);
        chk("rst_mid_LED", 32'(bus.LED), 32'h0);
        RST = 1'b0;
        for (int k = 0; k < 3; k++) tick();
        chk("held_thru_rst", 32'(bus.DIG), 32'h000);
        bus.SEL = 3'b000; tick();
        press(3'b100, 1);
        chk("repress", 32'(bus.DIG), 32'h100);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
